pwm_timebase_gen: RTL
=====================

Name: pwm_timebase_gen

Overview:
- Parametrised, double-buffered timebase counter; next generation of the single-mode 32-bit up-counter.
- Adds up, down and up-down (centre-aligned) modes, a terminal-count pulse, a compare output and shadow registers so period/compare/mode change glitch-free at period boundaries.
- Drives rover motor PWM channels and periodic ticks. One instance per channel.

Parameters:
- WIDTH, 32, counter/period/compare width in bits (legal range 2..32).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count enable; when low, count and dir hold.
- load  in  1  strobe; captures period_in/compare_in/mode_in into the shadow registers.
- period_in  in  WIDTH  requested period P.
- compare_in  in  WIDTH  requested compare value C.
- mode_in  in  2  00 up, 01 down, 10 up-down, 11 reserved (behaves as 00).
- count  out  WIDTH  current count, registered.
- dir  out  1  0 counting up, 1 counting down, registered.
- tc_pulse  out  1  high during the last cycle of a period (combinational from registers).
- cmp_out  out  1  count < active compare (combinational from registers).
- period_active  out  WIDTH  active period register, for software readback.

Behaviour:
- Registers: shadow {P_sh, C_sh, M_sh}; active {P_a, C_a, M_a}; count; dir.
- Reset: all registers 0. count=0, dir=0, tc_pulse=0, cmp_out=0, period_active=0. Reset overrides load and enable. Reset mid-period zeroes everything on the next edge.
- load=1: shadow <= inputs at the edge; no effect on the active set in that cycle, except through the bypass rule below.
- Update event (U): tc_pulse=1, or P_a==0 (idle; U fires every cycle regardless of enable). At U, active <= (load ? inputs : shadow). Same-cycle load therefore bypasses the shadow. count <= start value of the new mode: 0 for up/up-down, P_new-1 for down, P_new-1 computed in WIDTH bits. dir <= 0. If P_new==0: count <= 0.
- P_a==0: count=0, tc_pulse=0, cmp_out=0.
- tc_pulse requires enable=1 and P_a>=1:
  - Up: tc when count==P_a-1. Otherwise count+1. Sequence 0..P-1, length P.
  - Down: tc when count==0. Otherwise count-1. Sequence P-1..0, length P.
  - Up-down, dir=0: if count==P_a-1 and P_a<=2, tc. Else if count==P_a-1, dir<=1 and count<=P_a-2. Else count+1.
  - Up-down, dir=1: if count==1, tc (next count 0, dir 0). Else count-1.
  - Up-down period is 2P-2 cycles for P>=2 and 1 cycle for P==1. Example P=4: 0,1,2,3,2,1,0,...
- P_a==1: count stays 0 and tc_pulse is high on every enabled cycle in all modes.
- cmp_out = (count < C_a), unsigned WIDTH-bit compare. C_a==0 gives constant 0. C_a>=P_a gives constant 1 (100%). Up-down mode gives centre-aligned PWM.
- No arithmetic overflow: P_a-1 is evaluated only when P_a>=1. count never exceeds P_a-1.
- enable=0 with P_a>=1: count, dir and active registers hold, tc_pulse=0, and shadow loads still occur.
- period_active = P_a.

Test Plan:
- Reset then load P=5, C=2, mode=00, enable=1 -> one idle-update cycle, then count 0,1,2,3,4,0. tc_pulse high only at count=4. cmp_out high at counts 0,1.
- Mode=01, P=4 -> count 3,2,1,0,3. tc_pulse at 0. Mode=10, P=4 -> 0,1,2,3,2,1,0,1. tc_pulse at the descending 1. dir=1 on counts 3→1 after the peak.
- Mid-period load P=8 while running with P=5 -> count completes 0..4 unchanged, then 0..7. Load coincident with tc -> new values active on the next cycle (bypass).
- P=1 and P=2 in every mode -> P=1: tc every cycle, count=0. P=2 up-down: 0,1,0,1 with tc at each 1. C=0 gives cmp_out=0. C=9 with P=5 gives cmp_out=1.
- Assert reset at count=3 with enable high -> next cycle count=0, dir=0, outputs 0, period_active=0. Then drop enable for 3 cycles mid-period -> count frozen and tc_pulse=0 throughout.

Source files
------------

// File: rtl/pwm_timebase_gen.sv
// Double-buffered PWM timebase: up, down and centre-aligned up-down counting with
// shadow period/compare/mode registers that take effect only at period boundaries.
module pwm_timebase_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] compare_in,
  input  logic [1:0]       mode_in,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc_pulse,
  output logic             cmp_out,
  output logic [WIDTH-1:0] period_active
);

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UPDN = 2'b10;

  logic [WIDTH-1:0] r_p_sh, r_c_sh, r_p_a, r_c_a, r_count;
  logic [1:0]       r_m_sh, r_m_a;
  logic             r_dir;

  logic             w_idle, w_le2, w_at_top, w_tc, w_upd;
  logic [WIDTH-1:0] w_p_last, w_p_new, w_c_new, w_start;
  logic [1:0]       w_m_new;

  // Last count of an up ramp; held at zero while idle so P_a-1 never wraps.
  assign w_idle   = (r_p_a == '0);
  assign w_p_last = w_idle ? '0 : (r_p_a - WIDTH'(1));
  assign w_le2    = (r_p_a <= WIDTH'(2));
  assign w_at_top = (r_count == w_p_last);

  always_comb begin
    w_tc = 1'b0;
    if (enable && !w_idle) begin
      case (r_m_a)
        MODE_DOWN: w_tc = (r_count == '0);
        MODE_UPDN: w_tc = r_dir ? (r_count == WIDTH'(1)) : (w_at_top && w_le2);
        default:   w_tc = w_at_top;
      endcase
    end
  end

  // A load coincident with the update event bypasses the shadow registers.
  assign w_upd   = w_tc || w_idle;
  assign w_p_new = load ? period_in  : r_p_sh;
  assign w_c_new = load ? compare_in : r_c_sh;
  assign w_m_new = load ? mode_in    : r_m_sh;
  assign w_start = ((w_m_new == MODE_DOWN) && (w_p_new != '0)) ? (w_p_new - WIDTH'(1)) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_p_sh  <= '0;
      r_c_sh  <= '0;
      r_m_sh  <= '0;
      r_p_a   <= '0;
      r_c_a   <= '0;
      r_m_a   <= '0;
      r_count <= '0;
      r_dir   <= 1'b0;
    end else begin
      if (load) begin
        r_p_sh <= period_in;
        r_c_sh <= compare_in;
        r_m_sh <= mode_in;
      end
      if (w_upd) begin
        r_p_a   <= w_p_new;
        r_c_a   <= w_c_new;
        r_m_a   <= w_m_new;
        r_count <= w_start;
        r_dir   <= 1'b0;
      end else if (enable) begin
        case (r_m_a)
          MODE_DOWN: r_count <= r_count - WIDTH'(1);
          MODE_UPDN: begin
            if (r_dir) begin
              r_count <= r_count - WIDTH'(1);
            end else if (w_at_top) begin
              r_dir   <= 1'b1;
              r_count <= w_p_last - WIDTH'(1);
            end else begin
              r_count <= r_count + WIDTH'(1);
            end
          end
          default:   r_count <= r_count + WIDTH'(1);
        endcase
      end
    end
  end

  assign count         = r_count;
  assign dir           = r_dir;
  assign tc_pulse      = w_tc;
  assign cmp_out       = !w_idle && (r_count < r_c_a);
  assign period_active = r_p_a;

endmodule
